video_timing_gen: RTL and testbench
===================================

# video_timing_gen

Raster timing generator for the DVI video path. It produces pixel-clock-domain sync, data-enable and coordinate signals for 640x480@60 and 1280x720@60. It also gates the 24-bit fill colour onto the pixel bus. It sits between the APB register block, which supplies `res_switch` and the colour word, and the TMDS encoder/serialiser. Mode and colour changes take effect only at frame boundaries, so no frame is ever torn.

## Interface
Parameters: none. Both timing sets are fixed localparams.
- `clk`  in  1  pixel clock for the current mode. Clock selection and muxing happen outside this block.
- `reset`  in  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- `res_switch`  in  2  requested mode: 00 = 640x480; 01 = 1280x720; 10 and 11 are reserved and treated as 00.
- `color`  in  24  fill colour {R,G,B}, 8 bits each.
- `hsync`  out  1  horizontal sync, at the mode's polarity.
- `vsync`  out  1  vertical sync, at the mode's polarity.
- `de`  out  1  data enable; high only inside the active area.
- `x`  out  11  raw horizontal count.
- `y`  out  10  raw vertical count.
- `sof`  out  1  one-cycle pulse on pixel (0,0).
- `rgb`  out  24  pixel data: the latched colour when `de` is high, otherwise 0.
- `mode`  out  2  mode currently in effect (00 or 01).

## Operation
- Timing per mode. Each field lists active / front porch / sync / back porch, then the total.
  - Mode 00, horizontal: 640/16/96/48, total 800.
  - Mode 00, vertical: 480/10/2/33, total 525.
  - Mode 00 syncs are active-low.
  - Mode 01, horizontal: 1280/110/40/220, total 1650.
  - Mode 01, vertical: 720/5/5/20, total 750.
  - Mode 01 syncs are active-high.
- Internal counters: `h` runs 0..HTOT-1 and `v` runs 0..VTOT-1. Each line and each frame starts with its active region at count 0.
- Counter advance: `h` increments every cycle. When `h` = HTOT-1 it wraps to 0 and `v` increments. When `v` = VTOT-1 at that same wrap, `v` also wraps to 0.
- `de` = (h < HACT) and (v < VACT).
- hsync is asserted when h is in [HACT+HFP, HACT+HFP+HSYNC-1]:
  - mode 00: h = 656..751
  - mode 01: h = 1390..1429
- vsync is asserted, for whole lines, when v is in [VACT+VFP, VACT+VFP+VSYNC-1]:
  - mode 00: v = 490..491
  - mode 01: v = 725..729
- Asserted means level 0 in mode 00 and level 1 in mode 01. Otherwise the output holds the opposite level.
- `sof` = (h == 0) and (v == 0).
- Frame-boundary shadowing: `mode_q` and `color_q` load from `res_switch` (reserved codes folded to 00) and `color` on the edge where the counters wrap from (HTOT-1, VTOT-1) to (0,0). They load on no other edge, so changes mid-frame are invisible until the next frame.
- Counter terminal values always come from `mode_q`. A mode change therefore never truncates or extends the current frame.
- `x`/`y` are the raw counter values, including blanking. The maximums (1649, 749) fit the port widths with no overflow.

## Timing
- Latency: every output is a registered function of the counter values before the edge. Outputs lag the internal counters by one cycle.
- While `reset` is high, all of the following hold:
  - `h`, `v`, `x`, `y` = 0; `mode_q` = 00; `color_q` = 0.
  - `de` = 0, `sof` = 0, `rgb` = 0.
  - `hsync` = `vsync` = 1 (inactive level for mode 00); `mode` = 00.
- Reset does not sample `res_switch`. The first frame after reset is always 640x480, and the first real mode sample happens at the end of that frame.
- First edge with `reset` low: outputs show pixel (0,0) in mode 00. That means `de`=1, `sof`=1, `x`=`y`=0, `rgb`=0 (because `color_q`=0), and `hsync`=`vsync`=1.
- `mode`, the sync polarity and `rgb` all switch on the same output cycle as the `sof` of the new frame.
- Reset asserted mid-frame: the next edge forces the full reset state. There is no partial-frame completion.
- No handshake: the downstream encoder consumes one pixel every cycle unconditionally.

## Test plan
- Reset/startup: hold reset 5 cycles, then release. Expect:
  - all outputs at the reset values listed above;
  - first output cycle `sof`=1, `de`=1, `x`=0, `y`=0, `mode`=00.
- Mode 00 line/frame geometry, with `res_switch`=00:
  - `sof` period = 420000 cycles;
  - per line, `de` high for 640 cycles and `hsync` low exactly while `x`=656..751;
  - `vsync` low exactly for `y`=490..491;
  - `de`=0 for every `y` >= 480.
- Mode switch mid-frame: set `res_switch`=01 at `y`=100 of a mode-00 frame. Expect:
  - the current frame still lasts 420000 cycles;
  - the next frame has `mode`=01, a period of 1237500 cycles, and `hsync` high only for `x`=1390..1429;
  - `vsync` high for `y`=725..729.
- Reserved code: `res_switch`=11 at the frame boundary, while in mode 01. Expect:
  - the next frame has `mode`=00 and active-low syncs;
  - the frame period is 420000 cycles.
- Colour shadowing: change `color` from 0x000000 to 0xFF8000 at `y`=10 of a frame. Expect:
  - `rgb`=0 for the remainder of that frame;
  - `rgb`=0xFF8000 on every `de` cycle of the next frame;
  - `rgb`=0 whenever `de`=0.
- Reset mid-frame in mode 01: assert `reset` for one cycle at `x`=700, `y`=300. Expect:
  - the next cycle shows the full reset state;
  - after release, `mode`=00 and `sof` at (0,0), even though `res_switch` is still 01;
  - mode 01 returns only after the following frame boundary.

Source files
------------

// File: rtl/video_timing_gen.sv
`default_nettype none
// ============================================================================
// video_timing_gen : 640x480@60 / 1280x720@60 raster timing and fill-colour gate
// Rev 1.0 - initial release
// ============================================================================
module video_timing_gen (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  res_switch,
  input  logic [23:0] color,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [10:0] x,
  output logic [9:0]  y,
  output logic        sof,
  output logic [23:0] rgb,
  output logic [1:0]  mode
);

  localparam logic [10:0] c_H0_ACT = 11'd640;
  localparam logic [10:0] c_H0_HS0 = 11'd656;
  localparam logic [10:0] c_H0_HS1 = 11'd751;
  localparam logic [10:0] c_H0_END = 11'd799;
  localparam logic [9:0]  c_V0_ACT = 10'd480;
  localparam logic [9:0]  c_V0_VS0 = 10'd490;
  localparam logic [9:0]  c_V0_VS1 = 10'd491;
  localparam logic [9:0]  c_V0_END = 10'd524;

  localparam logic [10:0] c_H1_ACT = 11'd1280;
  localparam logic [10:0] c_H1_HS0 = 11'd1390;
  localparam logic [10:0] c_H1_HS1 = 11'd1429;
  localparam logic [10:0] c_H1_END = 11'd1649;
  localparam logic [9:0]  c_V1_ACT = 10'd720;
  localparam logic [9:0]  c_V1_VS0 = 10'd725;
  localparam logic [9:0]  c_V1_VS1 = 10'd729;
  localparam logic [9:0]  c_V1_END = 10'd749;

  logic [10:0] r_h;
  logic [9:0]  r_v;
  logic        r_mode_q;
  logic [23:0] r_color_q;

  logic [10:0] w_hact, w_hs0, w_hs1, w_hend;
  logic [9:0]  w_vact, w_vs0, w_vs1, w_vend;
  logic        w_h_last, w_v_last, w_de, w_hs_on, w_vs_on;

  // Geometry always follows the shadowed mode, so a frame never changes length.
  always_comb begin
    w_hact = c_H0_ACT;  w_hs0 = c_H0_HS0;  w_hs1 = c_H0_HS1;  w_hend = c_H0_END;
    w_vact = c_V0_ACT;  w_vs0 = c_V0_VS0;  w_vs1 = c_V0_VS1;  w_vend = c_V0_END;
    if (r_mode_q) begin
      w_hact = c_H1_ACT;  w_hs0 = c_H1_HS0;  w_hs1 = c_H1_HS1;  w_hend = c_H1_END;
      w_vact = c_V1_ACT;  w_vs0 = c_V1_VS0;  w_vs1 = c_V1_VS1;  w_vend = c_V1_END;
    end
  end

  assign w_h_last = (r_h == w_hend);
  assign w_v_last = (r_v == w_vend);
  assign w_de     = (r_h < w_hact) && (r_v < w_vact);
  assign w_hs_on  = (r_h >= w_hs0) && (r_h <= w_hs1);
  assign w_vs_on  = (r_v >= w_vs0) && (r_v <= w_vs1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_h       <= '0;
      r_v       <= '0;
      r_mode_q  <= 1'b0;
      r_color_q <= '0;
    end else if (w_h_last) begin
      r_h <= '0;
      if (w_v_last) begin
        r_v       <= '0;
        // Reserved codes 10/11 fold to 640x480.
        r_mode_q  <= (res_switch == 2'b01);
        r_color_q <= color;
      end else begin
        r_v <= r_v + 10'd1;
      end
    end else begin
      r_h <= r_h + 11'd1;
    end
  end

  // Mode 0 syncs are active-low, mode 1 active-high.
  always_ff @(posedge clk) begin
    if (reset) begin
      hsync <= 1'b1;
      vsync <= 1'b1;
      de    <= 1'b0;
      x     <= '0;
      y     <= '0;
      sof   <= 1'b0;
      rgb   <= '0;
      mode  <= 2'b00;
    end else begin
      hsync <= r_mode_q ? w_hs_on : ~w_hs_on;
      vsync <= r_mode_q ? w_vs_on : ~w_vs_on;
      de    <= w_de;
      x     <= r_h;
      y     <= r_v;
      sof   <= (r_h == 11'd0) && (r_v == 10'd0);
      rgb   <= w_de ? r_color_q : 24'd0;
      mode  <= {1'b0, r_mode_q};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_video_timing_gen.sv
`default_nettype none
// ============================================================================
// tb_video_timing_gen : scoreboard bench with a frame-level reference model
// Rev 1.0 - initial release
// ============================================================================
module tb_video_timing_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  res_switch;
  logic [23:0] color;
  logic        hsync, vsync, de, sof;
  logic [10:0] x;
  logic [9:0]  y;
  logic [23:0] rgb;
  logic [1:0]  mode;

  always #5 clk = ~clk;

  video_timing_gen dut (
    .clk(clk), .reset(reset), .res_switch(res_switch), .color(color),
    .hsync(hsync), .vsync(vsync), .de(de), .x(x), .y(y),
    .sof(sof), .rgb(rgb), .mode(mode)
  );

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic [10:0] x;
    logic [9:0]  y;
    logic        sof;
    logic [23:0] rgb;
    logic [1:0]  mode;
  } px_t;

  px_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  ncyc   = 0;

  // Reference state: pixel position, frame mode and frame colour.
  int          m_h = 0, m_v = 0, m_mode = 0;
  logic [23:0] m_color = '0;
  bit          rand_rs = 0, rand_col = 0;

  // Timing tables expressed as active / front porch / sync / back porch.
  function automatic void geom(input int md, output int act_h, output int fp_h,
                               output int sw_h, output int bp_h, output int act_v,
                               output int fp_v, output int sw_v, output int bp_v);
    if (md == 1) begin
      act_h = 1280; fp_h = 110; sw_h = 40; bp_h = 220;
      act_v = 720;  fp_v = 5;   sw_v = 5;  bp_v = 20;
    end else begin
      act_h = 640;  fp_h = 16;  sw_h = 96; bp_h = 48;
      act_v = 480;  fp_v = 10;  sw_v = 2;  bp_v = 33;
    end
  endfunction

  function automatic px_t pixel(input int h, input int v, input int md, input logic [23:0] col);
    int ah, fh, sh, bh, av, fv, sv, bv;
    px_t p;
    bit hs_on, vs_on;
    geom(md, ah, fh, sh, bh, av, fv, sv, bv);
    hs_on  = (h >= ah + fh) && (h < ah + fh + sh);
    vs_on  = (v >= av + fv) && (v < av + fv + sv);
    p.hs   = (md == 1) ? hs_on : !hs_on;
    p.vs   = (md == 1) ? vs_on : !vs_on;
    p.de   = (h < ah) && (v < av);
    p.x    = h[10:0];
    p.y    = v[9:0];
    p.sof  = (h == 0) && (v == 0);
    p.rgb  = p.de ? col : 24'd0;
    p.mode = md[1:0];
    return p;
  endfunction

  function automatic int htotal(input int md);
    int ah, fh, sh, bh, av, fv, sv, bv;
    geom(md, ah, fh, sh, bh, av, fv, sv, bv);
    return ah + fh + sh + bh;
  endfunction

  function automatic int vtotal(input int md);
    int ah, fh, sh, bh, av, fv, sv, bv;
    geom(md, ah, fh, sh, bh, av, fv, sv, bv);
    return av + fv + sv + bv;
  endfunction

  // One pixel clock: predict the output of the coming edge, then advance the model.
  task automatic cyc();
    px_t p;
    if (rand_rs)  res_switch = 2'($urandom_range(0, 3));
    if (rand_col && ($urandom_range(0, 63) == 0)) color = 24'($urandom);
    if (reset) begin
      p = '{hs: 1'b1, vs: 1'b1, default: '0};
      m_h = 0; m_v = 0; m_mode = 0; m_color = '0;
    end else begin
      p = pixel(m_h, m_v, m_mode, m_color);
      m_h++;
      if (m_h == htotal(m_mode)) begin
        m_h = 0;
        m_v++;
        if (m_v == vtotal(m_mode)) begin
          m_v = 0;
          m_mode = (res_switch == 2'b01) ? 1 : 0;
          m_color = color;
        end
      end
    end
    exp_q.push_back(p);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic run_until(input int hh, input int vv);
    int budget = 2_000_000;
    while (!(m_h == hh && m_v == vv) && budget > 0) begin
      cyc();
      budget--;
    end
    checks++;
    if (budget == 0) begin
      errors++;
      $display("FAIL run_until: position not reached, got h=%0d v=%0d want h=%0d v=%0d",
               m_h, m_v, hh, vv);
    end
  endtask

  // Fast-forward the vertical counter; model and design jump together.
  task automatic jump_v(input int t);
    force dut.r_v = 10'(t);
    #1;
    release dut.r_v;
    m_v = t;
  endtask

  initial begin : monitor
    px_t e, g;
    forever begin
      @(posedge clk);
      #1;
      ncyc++;
      g = '{hs: hsync, vs: vsync, de: de, x: x, y: y, sof: sof, rgb: rgb, mode: mode};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard: output at cycle %0d with no expected entry", ncyc);
      end else begin
        e = exp_q.pop_front();
        if (g !== e) begin
          errors++;
          if (errors <= 20)
            $display("FAIL pixel cyc=%0d got hs=%b vs=%b de=%b x=%0d y=%0d sof=%b rgb=%h mode=%0d | exp hs=%b vs=%b de=%b x=%0d y=%0d sof=%b rgb=%h mode=%0d",
                     ncyc, g.hs, g.vs, g.de, g.x, g.y, g.sof, g.rgb, g.mode,
                     e.hs, e.vs, e.de, e.x, e.y, e.sof, e.rgb, e.mode);
        end
      end
    end
  end

  initial begin : stimulus
    reset = 1'b1;
    res_switch = 2'b01;
    color = 24'hABCDEF;
    run(5);
    reset = 1'b0;

    // Mode 00 frame with random mid-frame requests that must stay invisible.
    color = 24'h000000;
    rand_rs = 1; rand_col = 1;
    run(3 * 800 + 37);
    jump_v(477);  run(3 * 800);
    jump_v(488);  run(5 * 800);
    jump_v(523);
    rand_rs = 0; rand_col = 0;
    res_switch = 2'b01;
    color = 24'hFF8000;
    run_until(0, 0);

    // Mode 01 frame, ending with a reserved request.
    rand_rs = 1; rand_col = 1;
    run(2 * 1650 + 13);
    jump_v(719);  run(13 * 1650);
    jump_v(748);
    rand_rs = 0; rand_col = 0;
    res_switch = 2'b11;
    color = 24'($urandom);
    run_until(0, 0);

    // Reserved code folds to mode 00; then return to mode 01.
    rand_rs = 1; rand_col = 1;
    run(1000);
    jump_v(524);
    rand_rs = 0; rand_col = 0;
    res_switch = 2'b01;
    color = 24'h123456;
    run_until(0, 0);

    // Reset mid-frame in mode 01; reset must not sample res_switch.
    run(500);
    jump_v(299);
    run_until(700, 300);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    run(2000);
    jump_v(524);
    run_until(0, 0);
    run(2000);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
